// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - shared constants and types for the PC sequencer
// Purpose: branch-type status codes, FSM state encoding, default reset PC
//          and small helpers used by pc_seq.
// Ports:   none (package).
package pc_seq_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Branch-type codes as delivered by the decoder on status[2:0].
    typedef enum logic [2:0] {
        CODE_SEQ     = 3'b000,
        CODE_BMN     = 3'b001,
        CODE_BRZ     = 3'b010,
        CODE_BZ      = 3'b011,
        CODE_JMOR    = 3'b100,
        CODE_JALM    = 3'b101,
        CODE_JSPAL   = 3'b110,
        CODE_ILLEGAL = 3'b111
    } status_e;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    // Every target written into the PC is word aligned.
    function automatic logic [31:0] align4(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    // Indirect transfers that also write a link register.
    function automatic logic is_link(input status_e code);
        return (code == CODE_JALM) || (code == CODE_JSPAL);
    endfunction

endpackage

// File: rtl/pc_flags.sv
// rtl/pc_flags.sv - registered N/Z/V condition flags
// Purpose: holds {n,z,v}; loads d when load=1, clears on reset.
// Ports:   clk, reset (sync, active-high), load, d[2:0] -> q[2:0].
module pc_flags (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [2:0] d,
    output logic [2:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= 3'b000;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pc_seq.sv
// rtl/pc_seq.sv - program counter sequencer with indirect-target fetch
// Purpose: selects the next PC from sequential, direct and register
//          targets, and fetches memory-indirect targets over a simple
//          req/ack data-memory read port while stalling the datapath.
// Ports:   clk, reset (sync, active-high)
//          status[2:0], flag_we, alu_n/alu_z/alu_v  - decoder and ALU inputs
//          reg_s, j_diraddr, ind_addr               - candidate targets
//          dm_req, dm_addr, dm_ack, dm_rdata        - indirect-target read port
//          pc, pc_plus4, stall, redirect, link_we, flags, illegal - outputs
module pc_seq
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  status,
    input  logic        flag_we,
    input  logic        alu_n,
    input  logic        alu_z,
    input  logic        alu_v,
    input  logic [31:0] reg_s,
    input  logic [31:0] j_diraddr,
    input  logic [31:0] ind_addr,
    output logic        dm_req,
    output logic [31:0] dm_addr,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        stall,
    output logic        redirect,
    output logic        link_we,
    output logic [2:0]  flags,
    output logic        illegal
);

    state_e      state;
    logic [31:0] cap_addr;
    status_e     cap_code;
    logic [31:0] pc_q;
    logic [2:0]  flags_q;

    status_e     code;
    logic        take_ind;
    logic        take_dir;
    logic [31:0] dir_target;

    assign code     = status_e'(status);
    assign pc       = pc_q;
    assign pc_plus4 = pc_q + 32'd4;
    assign flags    = flags_q;
    assign dm_addr  = cap_addr;
    // Gated by reset so an abandoned read drops its request immediately.
    assign dm_req   = (state == ST_WAIT) && !reset;

    // Branch decisions look only at the registered flags, never at the
    // ALU outputs of the same cycle.
    always_comb begin
        take_ind   = 1'b0;
        take_dir   = 1'b0;
        dir_target = reg_s;
        case (code)
            CODE_BMN:   take_ind = flags_q[2];
            CODE_BRZ: begin
                take_dir   = flags_q[1];
                dir_target = reg_s;
            end
            CODE_BZ: begin
                take_dir   = flags_q[1];
                dir_target = j_diraddr;
            end
            CODE_JMOR,
            CODE_JALM,
            CODE_JSPAL: take_ind = 1'b1;
            default:    ;
        endcase
    end

    // Handshake outputs qualify the instruction presented this cycle, so
    // they are decoded from the current state and inputs rather than
    // registered.
    always_comb begin
        stall    = 1'b0;
        redirect = 1'b0;
        link_we  = 1'b0;
        illegal  = 1'b0;
        if (!reset) begin
            if (state == ST_RUN) begin
                stall    = take_ind;
                redirect = take_dir;
                illegal  = (code == CODE_ILLEGAL);
            end else if (dm_ack) begin
                redirect = 1'b1;
                link_we  = is_link(cap_code);
            end else begin
                stall = 1'b1;
            end
        end
    end

    pc_flags u_flags (
        .clk   (clk),
        .reset (reset),
        .load  (flag_we && !stall),
        .d     ({alu_n, alu_z, alu_v}),
        .q     (flags_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_RUN;
            pc_q     <= RESET_PC;
            cap_addr <= 32'h0000_0000;
            cap_code <= CODE_SEQ;
        end else begin
            case (state)
                ST_RUN: begin
                    if (take_ind) begin
                        // PC holds; the fetched word becomes the target.
                        cap_addr <= ind_addr;
                        cap_code <= code;
                        state    <= ST_WAIT;
                    end else if (take_dir) begin
                        pc_q <= align4(dir_target);
                    end else begin
                        pc_q <= pc_q + 32'd4;
                    end
                end
                ST_WAIT: begin
                    if (dm_ack) begin
                        pc_q  <= align4(dm_rdata);
                        state <= ST_RUN;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_seq.sv
// tb/tb_pc_seq.sv - scoreboard bench for pc_seq
module tb_pc_seq;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  status;
    logic        flag_we, alu_n, alu_z, alu_v;
    logic [31:0] reg_s, j_diraddr, ind_addr;
    logic        dm_req;
    logic [31:0] dm_addr;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic [31:0] pc, pc_plus4;
    logic        stall, redirect, link_we, illegal;
    logic [2:0]  flags;

    pc_seq #(.RESET_PC(RST_PC)) dut (
        .clk       (clk),
        .reset     (reset),
        .status    (status),
        .flag_we   (flag_we),
        .alu_n     (alu_n),
        .alu_z     (alu_z),
        .alu_v     (alu_v),
        .reg_s     (reg_s),
        .j_diraddr (j_diraddr),
        .ind_addr  (ind_addr),
        .dm_req    (dm_req),
        .dm_addr   (dm_addr),
        .dm_ack    (dm_ack),
        .dm_rdata  (dm_rdata),
        .pc        (pc),
        .pc_plus4  (pc_plus4),
        .stall     (stall),
        .redirect  (redirect),
        .link_we   (link_we),
        .flags     (flags),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic [31:0] dm_addr;
        logic        stall;
        logic        redirect;
        logic        link_we;
        logic        illegal;
        logic        dm_req;
        logic [2:0]  flags;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_cyc = 0;

    // Reference model: architectural PC, flags, and a pending indirect fetch.
    logic [31:0] m_pc;
    logic [2:0]  m_flags;
    bit          m_wait;
    logic [31:0] m_addr;
    logic [2:0]  m_code;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %h required %h", name, n_cyc, act, req);
        end
    endtask

    // Monitor: every cycle the DUT presents a full output set; compare it
    // with the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pc",       pc,       e.pc);
                check("pc_plus4", pc_plus4, e.pc_plus4);
                check("stall",    {31'd0, stall},    {31'd0, e.stall});
                check("redirect", {31'd0, redirect}, {31'd0, e.redirect});
                check("link_we",  {31'd0, link_we},  {31'd0, e.link_we});
                check("illegal",  {31'd0, illegal},  {31'd0, e.illegal});
                check("dm_req",   {31'd0, dm_req},   {31'd0, e.dm_req});
                check("flags",    {29'd0, flags},    {29'd0, e.flags});
                if (e.dm_req) check("dm_addr", dm_addr, e.dm_addr);
                n_cyc++;
            end
        end
    end

    // Apply current inputs for one cycle: predict, push, advance the model.
    task automatic step();
        exp_t        e;
        logic        n, z, ind, dir;
        logic [31:0] nxt;
        e          = '0;
        e.pc       = m_pc;
        e.pc_plus4 = m_pc + 32'd4;
        e.flags    = m_flags;
        e.dm_addr  = m_addr;
        nxt        = m_pc;
        if (reset) begin
            exp_q.push_back(e);
            m_pc = RST_PC; m_flags = 3'b000; m_wait = 0; m_addr = 0; m_code = 0;
        end else begin
            if (!m_wait) begin
                n   = m_flags[2];
                z   = m_flags[1];
                ind = (status == 3'd1 && n) || status == 3'd4 || status == 3'd5 || status == 3'd6;
                dir = (status == 3'd2 || status == 3'd3) && z;
                e.illegal  = (status == 3'd7);
                e.stall    = ind;
                e.redirect = dir;
                if (ind) begin
                    m_wait = 1; m_addr = ind_addr; m_code = status;
                end else if (dir) begin
                    nxt = ((status == 3'd2) ? reg_s : j_diraddr) & 32'hFFFF_FFFC;
                end else begin
                    nxt = m_pc + 32'd4;
                end
            end else begin
                e.dm_req = 1'b1;
                if (dm_ack) begin
                    e.redirect = 1'b1;
                    e.link_we  = (m_code == 3'd5) || (m_code == 3'd6);
                    nxt        = dm_rdata & 32'hFFFF_FFFC;
                    m_wait     = 0;
                end else begin
                    e.stall = 1'b1;
                end
            end
            exp_q.push_back(e);
            if (flag_we && !e.stall) m_flags = {alu_n, alu_z, alu_v};
            m_pc = nxt;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 0; status = 3'd0; flag_we = 0; alu_n = 0; alu_z = 0; alu_v = 0;
        dm_ack = 0;
    endtask

    initial begin
        reset = 1; status = 0; flag_we = 0; alu_n = 0; alu_z = 0; alu_v = 0;
        reg_s = 0; j_diraddr = 0; ind_addr = 0; dm_ack = 0; dm_rdata = 0;
        repeat (2) @(posedge clk);
        #1;
        m_pc = RST_PC; m_flags = 0; m_wait = 0; m_addr = 0; m_code = 0;

        // Reset-state outputs, then sequential run from RESET_PC.
        step();
        idle();
        repeat (4) step();

        // Flag write z=1, then bz to an unaligned direct target.
        flag_we = 1; alu_z = 1; step();
        idle(); status = 3'd3; j_diraddr = 32'h0000_2003; step();
        idle(); step();
        // Jump to the top word, then wrap.
        status = 3'd3; j_diraddr = 32'hFFFF_FFFF; step();
        idle(); repeat (2) step();

        // bmn with n=1, ack after 3 WAIT cycles.
        flag_we = 1; alu_n = 1; step();
        idle(); status = 3'd1; ind_addr = 32'h0000_0040; step();
        repeat (3) begin
            idle(); status = 3'($urandom_range(0, 7)); step();
        end
        idle(); dm_ack = 1; dm_rdata = 32'h0000_0800; step();
        idle(); step();

        // jalm at pc 0x200 with ack on the first WAIT cycle.
        flag_we = 1; alu_z = 1; step();
        idle(); status = 3'd3; j_diraddr = 32'h0000_0200; step();
        idle(); status = 3'd5; ind_addr = 32'h0000_0080; step();
        idle(); dm_ack = 1; dm_rdata = 32'h0000_0300; step();
        idle(); step();

        // Reset during WAIT, late ack ignored.
        status = 3'd4; ind_addr = 32'h0000_00C0; step();
        idle(); step();
        reset = 1; step();
        idle(); dm_ack = 1; dm_rdata = 32'h0000_5000; step();
        idle(); step();

        // Illegal code, then flag write while stalled in WAIT.
        status = 3'd7; step();
        idle(); status = 3'd4; ind_addr = 32'h0000_0010; step();
        idle(); flag_we = 1; alu_n = 1; alu_z = 1; alu_v = 1; step();
        step();
        idle(); dm_ack = 1; dm_rdata = 32'h0000_0404; step();
        idle(); step();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            reset     = ($urandom_range(0, 39) == 0);
            status    = 3'($urandom_range(0, 7));
            flag_we   = $urandom_range(0, 1) == 1;
            alu_n     = $urandom_range(0, 1) == 1;
            alu_z     = $urandom_range(0, 1) == 1;
            alu_v     = $urandom_range(0, 1) == 1;
            reg_s     = $urandom;
            j_diraddr = $urandom;
            ind_addr  = $urandom;
            dm_ack    = ($urandom_range(0, 2) == 0);
            dm_rdata  = $urandom;
            step();
        end

        idle();
        repeat (2) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_seq.md
PC_SEQ -- requirements
Module: pc_seq

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 status  input  3  branch-type code {status2,status1,status0} from decoder.
REQ-005 flag_we  input  1  current instruction writes N/Z/V.
REQ-006 alu_n, alu_z, alu_v  input  1 each  ALU condition outputs.
REQ-007 reg_s  input  32  register-indirect target (brz).
REQ-008 j_diraddr  input  32  direct target (bz).
REQ-009 ind_addr  input  32  data-memory address holding the indirect target.
REQ-010 dm_req  output  1; dm_addr  output  32; dm_ack  input  1; dm_rdata  input  32  data-memory read port for indirect targets.
REQ-011 pc  output  32  current PC; pc_plus4  output  32  pc+4, mod 2^32.
REQ-012 stall  output  1  high: datapath SHALL NOT commit architectural state this cycle.
REQ-013 redirect  output  1  taken control transfer commits this cycle.
REQ-014 link_we  output  1  write pc_plus4 as link (jalm, jspal) this cycle.
REQ-015 flags  output  3  registered {n,z,v}; illegal  output  1  status==3'b111 seen in RUN.

Function
REQ-016 Codes: 000 seq; 001 bmn; 010 brz; 011 bz; 100 jmor; 101 jalm; 110 jspal; 111 illegal.
REQ-017 Branch conditions SHALL use registered flags, never alu_* of the same cycle.
REQ-018 flags SHALL load {alu_n,alu_z,alu_v} when flag_we=1 and stall=0; else hold.
REQ-019 FSM states RUN and WAIT only; reset state RUN.
REQ-020 RUN, 000/111, or 001 with n=0, or 010/011 with z=0: pc <= pc_plus4, redirect=0, stall=0.
REQ-021 RUN, 010 with z=1: pc <= reg_s; 011 with z=1: pc <= j_diraddr; redirect=1, stall=0, single cycle.
REQ-022 RUN, indirect taken (001 with n=1, 100, 101, 110): capture ind_addr and status, stall=1, pc held, next state WAIT.
REQ-023 WAIT: dm_req=1, dm_addr=captured address, stable until dm_ack; stall=1 while dm_ack=0.
REQ-024 WAIT with dm_ack=1: pc <= dm_rdata, redirect=1, stall=0, link_we=1 iff captured code 101 or 110, next state RUN.
REQ-025 dm_req SHALL be 0 in RUN; minimum indirect latency 2 cycles (RUN + one WAIT cycle).
REQ-026 Loaded targets SHALL have bits [1:0] forced to 00.
REQ-027 illegal SHALL pulse one cycle per RUN cycle with status==111; no other effect.
REQ-028 Status inputs SHALL be ignored in WAIT.
REQ-029 pc_plus4 wraps 32'hFFFF_FFFC -> 32'h0000_0000.

Reset
REQ-030 reset=1 at an edge: pc<=RESET_PC, flags<=000, state<=RUN, captured regs<=0, overriding all other inputs.
REQ-031 Reset during WAIT SHALL abandon the read; dm_req=0 from the following cycle; a late dm_ack is ignored.
REQ-032 During and after reset: stall, redirect, link_we, illegal, dm_req all 0.

Structure
REQ-033 Package pc_seq_pkg SHALL hold status code constants, FSM state encoding and the default RESET_PC.
REQ-034 Flag register is a natural sub-module named pc_flags (load-enable, sync reset); the FSM and PC mux stay in pc_seq.

Verification
REQ-035 Reset with RESET_PC=32'h0000_0100, then 3 cycles status=000 -> pc 0x100, 0x104, 0x108, 0x10C; redirect=0.
REQ-036 Flag write z=1, next cycle status=011, j_diraddr=0x0000_2003 -> pc=0x0000_2000, redirect=1 one cycle, no stall.
REQ-037 flags n=1, status=001, ind_addr=0x40, dm_ack after 3 WAIT cycles with dm_rdata=0x0000_0800 -> stall 4 cycles, dm_addr=0x40 stable, pc=0x800, link_we=0.
REQ-038 status=101 at pc=0x200, dm_ack on first WAIT cycle, dm_rdata=0x300 -> link_we=1 with pc_plus4=0x204, pc=0x300, total 2 cycles.
REQ-039 Reset asserted in WAIT, dm_ack one cycle later -> pc=RESET_PC, dm_req=0, ack ignored, state RUN.
REQ-040 status=111 in RUN -> illegal=1 one cycle, pc advances by 4, flags unchanged; flag_we=1 during WAIT stall -> flags unchanged.
